conv_addr_gen: RTL and testbench
================================

Name: conv_addr_gen

Overview:
- Parametrised successor to the single-mode IFM/filter address generator.
- Walks a full convolution layer and streams paired IFM and filter read addresses to the PE array over a valid/ready interface.
- Adds zero-padding, multi-tile output-channel grouping with a PE lane mask, an OFM writeback address with an end-of-accumulation flag, and back-pressure.
- Sits between the layer controller (start/done) and the IFM/filter SRAM read ports feeding TOTAL_PE PEs.

Parameters:
- TOTAL_PE, 16, PEs per tile; one output channel per PE.
- ADDR_W, 32, width of all address ports and base registers.
- DIM_W, 8, width of feature-map dimension and channel inputs.
- K_W, 4, width of the kernel-size input.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latches config when idle
- KERNEL_W  in  K_W  kernel width = height (K)
- IFM_W  in  DIM_W  IFM width = height
- IFM_C  in  DIM_W  input channels
- OFM_W  in  DIM_W  OFM width = height
- OFM_C  in  DIM_W  output channels
- stride  in  2  stride; 0 treated as 1
- pad  in  2  symmetric zero padding
- ifm_base  in  ADDR_W  IFM base (HWC, one element per address)
- flt_base  in  ADDR_W  filter base (one TOTAL_PE-wide word per address)
- ofm_base  in  ADDR_W  OFM base
- addr_ready  in  1  consumer accepts current beat
- addr_valid  out  1  beat valid
- req_addr_out_ifm  out  ADDR_W  IFM element address
- req_addr_out_filter  out  ADDR_W  filter word address
- ifm_pad  out  1  beat is padding; consumer injects zero, IFM address is 0
- acc_last  out  1  last beat of one output pixel
- ofm_addr  out  ADDR_W  writeback address; valid when acc_last
- pe_mask  out  TOTAL_PE  active PE lanes in the current tile
- busy  out  1  layer in progress
- done_compute  out  1  one-cycle pulse after the final transfer
- cfg_err  out  1  zero-sized config rejected; sticky until next start

Behaviour:
- Reset: all outputs 0; FSM to IDLE. A reset mid-layer aborts immediately with no done pulse.
- FSM states: IDLE, SETUP, RUN, DONE.
  - IDLE: on start, latch config and go to SETUP.
  - SETUP: one cycle of precompute (NT = ceil(OFM_C/TOTAL_PE), K*K*IFM_C, etc.), then RUN.
  - RUN: issue beats; after the final handshake go to DONE.
  - DONE: pulse done_compute, then IDLE.
- start is ignored unless in IDLE.
- Latency: start sampled at edge N; addr_valid=1 after edge N+2.
- Handshake:
  - A transfer occurs when addr_valid and addr_ready are both 1.
  - While addr_valid=1 and addr_ready=0, all beat outputs hold stable.
  - Throughput is one beat per cycle under continuous ready.
  - addr_valid never drops except after the last beat.
- Loop nest, outermost first: t in 0..NT-1, oy, ox in 0..OFM_W-1, ky, kx in 0..K-1, ic in 0..IFM_C-1.
- Address arithmetic:
  - iy = oy*stride + ky - pad, ix = ox*stride + kx - pad (signed).
  - If iy or ix is outside [0, IFM_W-1]: ifm_pad=1, req_addr_out_ifm=0.
  - Otherwise: req_addr_out_ifm = ifm_base + (iy*IFM_W + ix)*IFM_C + ic.
  - req_addr_out_filter = flt_base + t*K*K*IFM_C + (ky*K + kx)*IFM_C + ic.
  - acc_last=1 when ky=K-1, kx=K-1 and ic=IFM_C-1.
  - ofm_addr = ofm_base + (oy*OFM_W + ox)*NT + t.
  - pe_mask is all ones, except on the last tile, where it has the low (OFM_C - (NT-1)*TOTAL_PE) bits set.
- Width rules: internal products computed at ADDR_W bits and truncated modulo 2^ADDR_W; base + offset wraps silently.
- Zero config: if any of KERNEL_W, IFM_C, IFM_W, OFM_W, OFM_C is 0, go SETUP -> DONE with no beats; cfg_err=1 and done_compute pulses.
- done_compute and a new start in the same cycle cannot collide: start is only accepted in IDLE.

Optional Feature:
- Macro: CONV_ADDR_GEN_PERF_CNT_EN.
- Defined: adds two 32-bit outputs, both cleared on start and on rst, holding value after done:
  - perf_beats: count of transfers.
  - perf_stalls: count of cycles with addr_valid=1 and addr_ready=0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Basic stride: K=3, IFM_W=10, IFM_C=16, OFM_W=4, OFM_C=3, stride=2, pad=0, all bases 0, ready tied 1.
  - Exactly 2304 beats.
  - IFM addresses: 0..47 first, then 160.
  - Pixel ox=1 starts at IFM 32.
  - Filter cycles 0..143.
  - pe_mask=16'h0007.
  - done_compute pulses once.
- Padding: K=3, IFM_W=4, IFM_C=1, OFM_W=4, OFM_C=1, stride=1, pad=1.
  - First 9 beats: ifm_pad = 1,1,1,1,0,0,1,0,0.
  - Non-pad IFM addresses in those beats: 0,1,4,5.
  - acc_last on beat 9, with ofm_addr=0.
- Multi-tile: OFM_C=20, K=1, IFM_C=2, IFM_W=OFM_W=2, flt_base=100.
  - Tile 0: filter addresses 100,101; pe_mask=16'hFFFF.
  - Tile 1: filter addresses 102,103; pe_mask=16'h000F.
  - ofm_addr sequence 0,2,4,6,1,3,5,7.
- Back-pressure: random addr_ready at 50% duty.
  - Beat stream identical to the ready-tied-1 run.
  - Outputs stable during stalls.
  - With CONV_ADDR_GEN_PERF_CNT_EN: perf_stalls equals counted stall cycles.
- Zero config and reset abort:
  - start with IFM_C=0 -> no beats, cfg_err=1, done_compute 2 cycles after start.
  - rst mid-RUN -> addr_valid=0 next cycle, busy=0, no done_compute.
  - start while busy -> ignored.

Source files
------------

// File: rtl/conv_addr_gen.sv
// Convolution-layer address generator: streams paired IFM/filter read addresses with padding, tiling and OFM writeback info.
// Optional performance counters are enabled by defining CONV_ADDR_GEN_PERF_CNT_EN.
module conv_addr_gen #(
    parameter int TOTAL_PE = 16,
    parameter int ADDR_W   = 32,
    parameter int DIM_W    = 8,
    parameter int K_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [K_W-1:0]      KERNEL_W,
    input  logic [DIM_W-1:0]    IFM_W,
    input  logic [DIM_W-1:0]    IFM_C,
    input  logic [DIM_W-1:0]    OFM_W,
    input  logic [DIM_W-1:0]    OFM_C,
    input  logic [1:0]          stride,
    input  logic [1:0]          pad,
    input  logic [ADDR_W-1:0]   ifm_base,
    input  logic [ADDR_W-1:0]   flt_base,
    input  logic [ADDR_W-1:0]   ofm_base,
    input  logic                addr_ready,
    output logic                addr_valid,
    output logic [ADDR_W-1:0]   req_addr_out_ifm,
    output logic [ADDR_W-1:0]   req_addr_out_filter,
    output logic                ifm_pad,
    output logic                acc_last,
    output logic [ADDR_W-1:0]   ofm_addr,
    output logic [TOTAL_PE-1:0] pe_mask,
    output logic                busy,
    output logic                done_compute,
    output logic                cfg_err,
    output logic [1:0]          dbg_state
`ifdef CONV_ADDR_GEN_PERF_CNT_EN
   ,output logic [31:0]         perf_beats,
    output logic [31:0]         perf_stalls
`endif
);

    // Handshake: a beat transfers on a cycle where addr_valid && addr_ready; while
    // addr_valid is high and addr_ready low every beat output holds its value.
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

    localparam int SW = ADDR_W + 2;

    state_t                r_state;
    logic [K_W-1:0]        r_k;
    logic [DIM_W-1:0]      r_ifm_w, r_ifm_c, r_ofm_w, r_ofm_c;
    logic [1:0]            r_stride, r_pad;
    logic [ADDR_W-1:0]     r_ifm_base, r_flt_base, r_ofm_base;
    logic [ADDR_W-1:0]     r_nt, r_kkc;
    logic [TOTAL_PE-1:0]   r_last_mask;
    logic [DIM_W-1:0]      r_t, r_oy, r_ox, r_ic;
    logic [K_W-1:0]        r_ky, r_kx;
    logic                  r_exhausted;
    logic                  r_valid, r_pad_out, r_last_out, r_busy, r_done, r_cfg_err;
    logic [ADDR_W-1:0]     r_ifm_out, r_flt_out, r_ofm_out;
    logic [TOTAL_PE-1:0]   r_mask_out;
`ifdef CONV_ADDR_GEN_PERF_CNT_EN
    logic [31:0]           r_perf_beats, r_perf_stalls;
`endif

    logic [ADDR_W-1:0]     w_nt, w_rem, w_kkc;
    logic [TOTAL_PE-1:0]   w_last_mask;
    logic                  w_zero;
    logic [SW-1:0]         w_iy, w_ix;
    logic                  w_iy_ok, w_ix_ok, w_pad;
    logic [ADDR_W-1:0]     w_ifm, w_flt, w_ofm;
    logic                  w_ic_max, w_kx_max, w_ky_max, w_ox_max, w_oy_max, w_t_max;
    logic                  w_last, w_final;
    logic [TOTAL_PE-1:0]   w_mask;
    logic                  w_xfer, w_load;

    // Per-layer constants, evaluated from the latched configuration during SETUP.
    always_comb begin
        w_nt   = (ADDR_W'(r_ofm_c) + ADDR_W'(TOTAL_PE - 1)) / ADDR_W'(TOTAL_PE);
        w_rem  = ADDR_W'(r_ofm_c) - (w_nt - ADDR_W'(1)) * ADDR_W'(TOTAL_PE);
        w_kkc  = ADDR_W'(r_k) * ADDR_W'(r_k) * ADDR_W'(r_ifm_c);
        w_zero = (r_k == '0) || (r_ifm_c == '0) || (r_ifm_w == '0) ||
                 (r_ofm_w == '0) || (r_ofm_c == '0);
        w_last_mask = '0;
        for (int i = 0; i < TOTAL_PE; i++) begin
            w_last_mask[i] = (ADDR_W'(i) < w_rem);
        end
    end

    // Beat fields for the loop position held in the counters.
    always_comb begin
        w_iy    = SW'(r_oy) * SW'(r_stride) + SW'(r_ky) - SW'(r_pad);
        w_ix    = SW'(r_ox) * SW'(r_stride) + SW'(r_kx) - SW'(r_pad);
        w_iy_ok = !w_iy[SW-1] && (w_iy < SW'(r_ifm_w));
        w_ix_ok = !w_ix[SW-1] && (w_ix < SW'(r_ifm_w));
        w_pad   = !(w_iy_ok && w_ix_ok);
        w_ifm   = w_pad ? '0 :
                  r_ifm_base + (w_iy[ADDR_W-1:0] * ADDR_W'(r_ifm_w) + w_ix[ADDR_W-1:0])
                             * ADDR_W'(r_ifm_c) + ADDR_W'(r_ic);
        w_flt   = r_flt_base + ADDR_W'(r_t) * r_kkc
                + (ADDR_W'(r_ky) * ADDR_W'(r_k) + ADDR_W'(r_kx)) * ADDR_W'(r_ifm_c)
                + ADDR_W'(r_ic);
        w_ofm   = r_ofm_base + (ADDR_W'(r_oy) * ADDR_W'(r_ofm_w) + ADDR_W'(r_ox)) * r_nt
                + ADDR_W'(r_t);
        w_ic_max = (r_ic == r_ifm_c - DIM_W'(1));
        w_kx_max = (r_kx == r_k - K_W'(1));
        w_ky_max = (r_ky == r_k - K_W'(1));
        w_ox_max = (r_ox == r_ofm_w - DIM_W'(1));
        w_oy_max = (r_oy == r_ofm_w - DIM_W'(1));
        w_t_max  = (ADDR_W'(r_t) == r_nt - ADDR_W'(1));
        w_last   = w_ic_max && w_kx_max && w_ky_max;
        w_final  = w_last && w_ox_max && w_oy_max && w_t_max;
        w_mask   = w_t_max ? r_last_mask : '1;
        w_xfer   = r_valid && addr_ready;
        w_load   = (r_state == S_RUN) && !r_exhausted && (!r_valid || addr_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_ifm_w     <= '0;
            r_ifm_c     <= '0;
            r_ofm_w     <= '0;
            r_ofm_c     <= '0;
            r_stride    <= '0;
            r_pad       <= '0;
            r_ifm_base  <= '0;
            r_flt_base  <= '0;
            r_ofm_base  <= '0;
            r_nt        <= '0;
            r_kkc       <= '0;
            r_last_mask <= '0;
            r_t         <= '0;
            r_oy        <= '0;
            r_ox        <= '0;
            r_ky        <= '0;
            r_kx        <= '0;
            r_ic        <= '0;
            r_exhausted <= 1'b0;
            r_valid     <= 1'b0;
            r_pad_out   <= 1'b0;
            r_last_out  <= 1'b0;
            r_ifm_out   <= '0;
            r_flt_out   <= '0;
            r_ofm_out   <= '0;
            r_mask_out  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
`ifdef CONV_ADDR_GEN_PERF_CNT_EN
            r_perf_beats  <= '0;
            r_perf_stalls <= '0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef CONV_ADDR_GEN_PERF_CNT_EN
            if (r_state == S_RUN && r_valid) begin
                if (addr_ready) r_perf_beats  <= r_perf_beats + 32'd1;
                else            r_perf_stalls <= r_perf_stalls + 32'd1;
            end
`endif
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_k        <= KERNEL_W;
                        r_ifm_w    <= IFM_W;
                        r_ifm_c    <= IFM_C;
                        r_ofm_w    <= OFM_W;
                        r_ofm_c    <= OFM_C;
                        r_stride   <= (stride == 2'd0) ? 2'd1 : stride;
                        r_pad      <= pad;
                        r_ifm_base <= ifm_base;
                        r_flt_base <= flt_base;
                        r_ofm_base <= ofm_base;
                        r_cfg_err  <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef CONV_ADDR_GEN_PERF_CNT_EN
                        r_perf_beats  <= '0;
                        r_perf_stalls <= '0;
`endif
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_nt        <= w_nt;
                    r_kkc       <= w_kkc;
                    r_last_mask <= w_last_mask;
                    r_t         <= '0;
                    r_oy        <= '0;
                    r_ox        <= '0;
                    r_ky        <= '0;
                    r_kx        <= '0;
                    r_ic        <= '0;
                    r_exhausted <= 1'b0;
                    r_valid     <= 1'b0;
                    if (w_zero) begin
                        r_cfg_err <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_xfer && r_exhausted) begin
                        r_valid <= 1'b0;
                        r_state <= S_DONE;
                    end else if (w_load) begin
                        r_valid    <= 1'b1;
                        r_pad_out  <= w_pad;
                        r_last_out <= w_last;
                        r_ifm_out  <= w_ifm;
                        r_flt_out  <= w_flt;
                        r_ofm_out  <= w_ofm;
                        r_mask_out <= w_mask;
                        // Odometer advance, innermost (ic) first.
                        if (w_final) begin
                            r_exhausted <= 1'b1;
                        end else if (!w_ic_max) begin
                            r_ic <= r_ic + DIM_W'(1);
                        end else begin
                            r_ic <= '0;
                            if (!w_kx_max) begin
                                r_kx <= r_kx + K_W'(1);
                            end else begin
                                r_kx <= '0;
                                if (!w_ky_max) begin
                                    r_ky <= r_ky + K_W'(1);
                                end else begin
                                    r_ky <= '0;
                                    if (!w_ox_max) begin
                                        r_ox <= r_ox + DIM_W'(1);
                                    end else begin
                                        r_ox <= '0;
                                        if (!w_oy_max) begin
                                            r_oy <= r_oy + DIM_W'(1);
                                        end else begin
                                            r_oy <= '0;
                                            r_t  <= r_t + DIM_W'(1);
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign addr_valid          = r_valid;
    assign req_addr_out_ifm    = r_ifm_out;
    assign req_addr_out_filter = r_flt_out;
    assign ifm_pad             = r_pad_out;
    assign acc_last            = r_last_out;
    assign ofm_addr            = r_ofm_out;
    assign pe_mask             = r_mask_out;
    assign busy                = r_busy;
    assign done_compute        = r_done;
    assign cfg_err             = r_cfg_err;
    assign dbg_state           = r_state;
`ifdef CONV_ADDR_GEN_PERF_CNT_EN
    assign perf_beats          = r_perf_beats;
    assign perf_stalls         = r_perf_stalls;
`endif

endmodule

// File: tb/tb_conv_addr_gen.sv
// Directed bench for conv_addr_gen: stride, padding, multi-tile, back-pressure, zero config and reset abort.
module tb_conv_addr_gen;
    localparam int TP = 16;
    localparam int BW = 114; // {pad, last, mask[15:0], ifm[31:0], flt[31:0], ofm[31:0]}

    logic        clk = 1'b0;
    logic        rst, start, addr_ready;
    logic [3:0]  k;
    logic [7:0]  ifm_w, ifm_c, ofm_w, ofm_c;
    logic [1:0]  stride, pad;
    logic [31:0] ifm_base, flt_base, ofm_base;
    logic        addr_valid, ifm_pad, acc_last, busy, done_compute, cfg_err;
    logic [31:0] req_addr_out_ifm, req_addr_out_filter, ofm_addr;
    logic [15:0] pe_mask;
    logic [1:0]  dbg_state;
`ifdef CONV_ADDR_GEN_PERF_CNT_EN
    logic [31:0] perf_beats, perf_stalls;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [BW-1:0] got_q[$];
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] ref_q[$];

    conv_addr_gen dut (
        .clk(clk), .rst(rst), .start(start), .KERNEL_W(k), .IFM_W(ifm_w), .IFM_C(ifm_c),
        .OFM_W(ofm_w), .OFM_C(ofm_c), .stride(stride), .pad(pad), .ifm_base(ifm_base),
        .flt_base(flt_base), .ofm_base(ofm_base), .addr_ready(addr_ready),
        .addr_valid(addr_valid), .req_addr_out_ifm(req_addr_out_ifm),
        .req_addr_out_filter(req_addr_out_filter), .ifm_pad(ifm_pad), .acc_last(acc_last),
        .ofm_addr(ofm_addr), .pe_mask(pe_mask), .busy(busy), .done_compute(done_compute),
        .cfg_err(cfg_err), .dbg_state(dbg_state)
`ifdef CONV_ADDR_GEN_PERF_CNT_EN
       ,.perf_beats(perf_beats), .perf_stalls(perf_stalls)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] cur_beat();
        return {ifm_pad, acc_last, pe_mask, req_addr_out_ifm, req_addr_out_filter, ofm_addr};
    endfunction

    function automatic logic [BW-1:0] beat_at(int i);
        logic [BW-1:0] b;
        b = 'x;
        if (i < got_q.size()) b = got_q[i];
        return b;
    endfunction

    function automatic logic [31:0] f_ifm(int i);
        logic [BW-1:0] b;
        b = beat_at(i);
        return b[95:64];
    endfunction

    function automatic logic [31:0] f_flt(int i);
        logic [BW-1:0] b;
        b = beat_at(i);
        return b[63:32];
    endfunction

    function automatic logic [31:0] f_ofm(int i);
        logic [BW-1:0] b;
        b = beat_at(i);
        return b[31:0];
    endfunction

    function automatic logic [15:0] f_mask(int i);
        logic [BW-1:0] b;
        b = beat_at(i);
        return b[111:96];
    endfunction

    function automatic logic f_pad(int i);
        logic [BW-1:0] b;
        b = beat_at(i);
        return b[113];
    endfunction

    function automatic logic f_last(int i);
        logic [BW-1:0] b;
        b = beat_at(i);
        return b[112];
    endfunction

    // Driver tasks
    task automatic set_cfg(input int kk, input int iw, input int ic, input int ow, input int oc,
                           input int s, input int p, input int ib, input int fb, input int ob);
        k = 4'(kk); ifm_w = 8'(iw); ifm_c = 8'(ic); ofm_w = 8'(ow); ofm_c = 8'(oc);
        stride = 2'(s); pad = 2'(p);
        ifm_base = 32'(ib); flt_base = 32'(fb); ofm_base = 32'(ob);
    endtask

    // Reference loop nest over the current configuration.
    task automatic gen_expected();
        int kk, iw, icn, ow, oc, s, p, nt, rem, iy, ix;
        logic padb, last;
        logic [15:0] mask;
        logic [31:0] a_ifm, a_flt, a_ofm;
        kk = int'(k); iw = int'(ifm_w); icn = int'(ifm_c); ow = int'(ofm_w); oc = int'(ofm_c);
        s = (stride == 2'd0) ? 1 : int'(stride);
        p = int'(pad);
        nt = (oc + TP - 1) / TP;
        rem = oc - (nt - 1) * TP;
        exp_q.delete();
        for (int t = 0; t < nt; t++)
            for (int oy = 0; oy < ow; oy++)
                for (int ox = 0; ox < ow; ox++)
                    for (int ky = 0; ky < kk; ky++)
                        for (int kx = 0; kx < kk; kx++)
                            for (int c = 0; c < icn; c++) begin
                                iy = oy * s + ky - p;
                                ix = ox * s + kx - p;
                                padb  = (iy < 0) || (iy >= iw) || (ix < 0) || (ix >= iw);
                                a_ifm = padb ? 32'd0 : ifm_base + 32'((iy * iw + ix) * icn + c);
                                a_flt = flt_base + 32'(t * kk * kk * icn + (ky * kk + kx) * icn + c);
                                a_ofm = ofm_base + 32'((oy * ow + ox) * nt + t);
                                last  = (ky == kk - 1) && (kx == kk - 1) && (c == icn - 1);
                                mask  = (t == nt - 1) ? 16'((32'd1 << rem) - 32'd1) : 16'hFFFF;
                                exp_q.push_back({padb, last, mask, a_ifm, a_flt, a_ofm});
                            end
    endtask

    // Pulses start, then collects beats until done_compute or the cycle budget expires.
    task automatic run_layer(input bit rnd, input bit disturb, output int first_valid,
                             output int done_cyc, output int dones, output int stalls);
        bit held;
        logic [BW:0] hold_val;
        got_q.delete();
        first_valid = -1; done_cyc = -1; dones = 0; stalls = 0; held = 1'b0; hold_val = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (held) check("stall_hold", {addr_valid, cur_beat()}, hold_val);
            start = 1'b0;
            if (disturb && cyc == 5) begin
                start = 1'b1;
                ifm_c = 8'd0;
                k = 4'd2;
            end
            if (done_compute) begin
                dones++;
                done_cyc = cyc;
                break;
            end
            if (addr_valid && first_valid < 0) first_valid = cyc;
            addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held = 1'b0;
            if (addr_valid && addr_ready) begin
                got_q.push_back(cur_beat());
            end else if (addr_valid) begin
                stalls++;
                held = 1'b1;
                hold_val = {1'b1, cur_beat()};
            end
            tick();
        end
        start = 1'b0;
        addr_ready = 1'b1;
    endtask

    // Scoreboard: compares collected beats against exp_q.
    task automatic compare_stream(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        check({tag, "_content"}, bad, 0);
    endtask

    initial begin
        int fv, dc, dn, st, bad;
        logic [8:0]  padv;
        logic [31:0] ofms;
        int j;

        rst = 1'b1; start = 1'b0; addr_ready = 1'b1;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check("rst_valid", addr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done_compute, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_addrs", {req_addr_out_ifm, req_addr_out_filter, ofm_addr}, 0);
        check("rst_flags", {ifm_pad, acc_last, pe_mask}, 0);
        rst = 1'b0;
        tick();

        // Basic stride, ready tied high
        set_cfg(3, 10, 16, 4, 3, 2, 0, 0, 0, 0);
        gen_expected();
        run_layer(1'b0, 1'b0, fv, dc, dn, st);
        check("basic_beats", got_q.size(), 2304);
        check("basic_latency", fv, 2);
        check("basic_done_cycle", dc, 2307);
        check("basic_done_once", dn, 1);
        check("basic_ifm0", f_ifm(0), 0);
        check("basic_ifm47", f_ifm(47), 47);
        check("basic_ifm48", f_ifm(48), 160);
        check("basic_ox1_start", f_ifm(144), 32);
        check("basic_flt143", f_flt(143), 143);
        check("basic_flt_wrap", f_flt(144), 0);
        check("basic_mask", f_mask(0), 16'h0007);
        check("basic_last142", f_last(142), 0);
        check("basic_last143", {f_last(143), f_ofm(143)}, {1'b1, 32'd0});
        check("basic_ofm_px1", f_ofm(287), 1);
        compare_stream("basic_model");
`ifdef CONV_ADDR_GEN_PERF_CNT_EN
        check("basic_perf_beats", perf_beats, 2304);
        check("basic_perf_stalls", perf_stalls, 0);
`endif
        ref_q = got_q;
        tick();
        check("basic_idle_after_done", {busy, done_compute}, 0);

        // Back-pressure on the same layer
        run_layer(1'b1, 1'b0, fv, dc, dn, st);
        bad = 0;
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            if (got_q[i] !== ref_q[i]) bad++;
        check("bp_len", got_q.size(), ref_q.size());
        check("bp_content", bad, 0);
        check("bp_done_once", dn, 1);
        check("bp_stalls_seen", st > 0, 1);
`ifdef CONV_ADDR_GEN_PERF_CNT_EN
        check("bp_perf_beats", perf_beats, 2304);
        check("bp_perf_stalls", perf_stalls, st);
`endif
        tick();

        // Multi-tile, with a start pulse and config change while busy
        set_cfg(1, 2, 2, 2, 20, 1, 0, 0, 100, 0);
        gen_expected();
        run_layer(1'b0, 1'b1, fv, dc, dn, st);
        check("mt_beats", got_q.size(), 16);
        check("mt_t0_flt", {f_flt(0), f_flt(1)}, {32'd100, 32'd101});
        check("mt_t1_flt", {f_flt(8), f_flt(9)}, {32'd102, 32'd103});
        check("mt_t0_mask", f_mask(0), 16'hFFFF);
        check("mt_t1_mask", f_mask(8), 16'h000F);
        ofms = '0;
        j = 0;
        for (int i = 0; i < got_q.size(); i++)
            if (f_last(i) && j < 8) begin
                ofms[31 - 4*j -: 4] = f_ofm(i)[3:0];
                j++;
            end
        check("mt_ofm_seq", ofms, 32'h0246_1357);
        check("mt_done_once", dn, 1);
        check("mt_no_cfg_err", cfg_err, 0);
        compare_stream("mt_model");
        tick();

        // Zero config
        set_cfg(3, 10, 0, 4, 3, 1, 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_c0", {addr_valid, done_compute}, 0);
        tick();
        check("zero_c1", {addr_valid, done_compute}, 0);
        tick();
        check("zero_c2", {addr_valid, done_compute, cfg_err}, 3'b011);
        tick();
        check("zero_c3", {addr_valid, done_compute, cfg_err}, 3'b001);

        // Reset mid-RUN
        set_cfg(3, 10, 16, 4, 3, 2, 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        check("abort_running", {addr_valid, busy}, 2'b11);
        rst = 1'b1;
        tick();
        check("abort_outputs", {addr_valid, busy, done_compute, cfg_err, dbg_state}, 0);
        rst = 1'b0;
        dn = 0;
        repeat (10) begin
            tick();
            if (done_compute) dn++;
        end
        check("abort_no_done", dn, 0);

        // Padding
        set_cfg(3, 4, 1, 4, 1, 1, 1, 0, 0, 0);
        gen_expected();
        run_layer(1'b0, 1'b0, fv, dc, dn, st);
        padv = '0;
        for (int i = 0; i < 9; i++) padv[8 - i] = f_pad(i);
        check("pad_pattern", padv, 9'b111100100);
        check("pad_ifm_zero", f_ifm(0), 0);
        check("pad_ifm_valid", {f_ifm(4), f_ifm(5), f_ifm(7), f_ifm(8)},
              {32'd0, 32'd1, 32'd4, 32'd5});
        check("pad_last7", f_last(7), 0);
        check("pad_last8", {f_last(8), f_ofm(8)}, {1'b1, 32'd0});
        check("pad_beats", got_q.size(), 144);
        check("pad_done_once", dn, 1);
        check("pad_cfg_err_cleared", cfg_err, 0);
        compare_stream("pad_model");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
